// File: rtl/mem_access_pkg.sv
// Shared encodings and request payload for the load/store memory access unit.
package mem_access_pkg;

    localparam int unsigned MEM_WORDS_DEFAULT = 128;
    localparam int unsigned DATA_W            = 32;
    localparam int unsigned STORE_LANE_W      = 16;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Request fields held for the life of one access; only the low half of
    // the store data is ever needed after accept (word stores write at once).
    typedef struct packed {
        logic                      write;
        logic [1:0]                size;
        logic                      is_signed;
        logic [DATA_W-1:0]         addr;
        logic [STORE_LANE_W-1:0]   wdata;
    } req_t;

    function automatic logic [DATA_W-1:0] word_index(input logic [DATA_W-1:0] addr);
        return {2'b00, addr[DATA_W-1:2]};
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: extracts/extends load lanes and merges sub-word store data.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [DATA_W-1:0]       word,
    input  logic [STORE_LANE_W-1:0] wdata,
    input  logic [1:0]              offset,
    input  logic [1:0]              size,
    input  logic                    is_signed,
    output logic [DATA_W-1:0]       load_data_c,
    output logic [DATA_W-1:0]       store_data_c
);

    logic [4:0]        byte_sh;
    logic [4:0]        half_sh;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] ins;

    assign byte_sh = {offset, 3'b000};
    assign half_sh = {offset[1], 4'b0000};

    always_comb begin
        lane_b       = 8'(word >> byte_sh);
        lane_h       = 16'(word >> half_sh);
        load_data_c  = word;
        mask         = '0;
        ins          = '0;
        case (size)
            SZ_BYTE: begin
                load_data_c = is_signed ? {{24{lane_b[7]}}, lane_b} : {24'h0, lane_b};
                mask        = 32'h0000_00FF << byte_sh;
                ins         = 32'(wdata[7:0]) << byte_sh;
            end
            SZ_HALF: begin
                load_data_c = is_signed ? {{16{lane_h[15]}}, lane_h} : {16'h0, lane_h};
                mask        = 32'h0000_FFFF << half_sh;
                ins         = 32'(wdata) << half_sh;
            end
            default: begin
                load_data_c = word;
            end
        endcase
        // Untouched lanes keep the word just read from memory.
        store_data_c = (word & ~mask) | ins;
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator: one request at a time, RMW for sub-word stores, registered memory strobes.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] Address,
    output logic [31:0] WriteData,
    input  logic [31:0] ReadData
);

    state_t      state, state_d;
    req_t        lat, lat_d;
    logic        ready_d;
    logic        resp_valid_d;
    logic        resp_err_d;
    logic [31:0] resp_rdata_d;
    logic        mem_read_d;
    logic        mem_write_d;
    logic [31:0] address_d;
    logic [31:0] write_data_d;
    logic        req_err_c;
    logic [31:0] load_data_c;
    logic [31:0] store_data_c;

    mem_lane_align u_align (
        .word         (ReadData),
        .wdata        (lat.wdata),
        .offset       (lat.addr[1:0]),
        .size         (lat.size),
        .is_signed    (lat.is_signed),
        .load_data_c  (load_data_c),
        .store_data_c (store_data_c)
    );

    // Misalignment, reserved size and range checks on the incoming request.
    always_comb begin
        req_err_c = 1'b0;
        case (req_size)
            SZ_BYTE: req_err_c = 1'b0;
            SZ_HALF: req_err_c = req_addr[0];
            SZ_WORD: req_err_c = (req_addr[1:0] != 2'b00);
            default: req_err_c = 1'b1;
        endcase
        if (word_index(req_addr) >= 32'(MEM_WORDS)) begin
            req_err_c = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state      <= ST_IDLE;
            lat        <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            MemRead    <= 1'b0;
            MemWrite   <= 1'b0;
            Address    <= '0;
            WriteData  <= '0;
        end else begin
            state      <= state_d;
            lat        <= lat_d;
            req_ready  <= ready_d;
            resp_valid <= resp_valid_d;
            resp_err   <= resp_err_d;
            resp_rdata <= resp_rdata_d;
            MemRead    <= mem_read_d;
            MemWrite   <= mem_write_d;
            Address    <= address_d;
            WriteData  <= write_data_d;
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_d      = state;
        lat_d        = lat;
        ready_d      = 1'b0;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        address_d    = '0;
        write_data_d = '0;
        case (state)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (req_valid && req_ready) begin
                    ready_d = 1'b0;
                    lat_d   = '{write:     req_write,
                                size:      req_size,
                                is_signed: req_signed,
                                addr:      req_addr,
                                wdata:     req_wdata[STORE_LANE_W-1:0]};
                    if (req_err_c) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (req_write && (req_size == SZ_WORD)) begin
                        state_d      = ST_WR;
                        mem_write_d  = 1'b1;
                        address_d    = word_index(req_addr);
                        write_data_d = req_wdata;
                    end else begin
                        state_d    = ST_RD;
                        mem_read_d = 1'b1;
                        address_d  = word_index(req_addr);
                    end
                end
            end
            ST_RD: begin
                if (lat.write) begin
                    state_d      = ST_WR;
                    mem_write_d  = 1'b1;
                    address_d    = word_index(lat.addr);
                    write_data_d = store_data_c;
                end else begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_data_c;
                end
            end
            ST_WR: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vectors, corner sequences, random vs byte-level model.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic        CLK;
    logic        RSTn;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;

    int checks = 0;
    int errors = 0;

    mem_access_unit #(.MEM_WORDS(128)) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Address    (Address),
        .WriteData  (WriteData),
        .ReadData   (ReadData)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Word-addressed memory responder
    logic [31:0] dmem [128];
    logic        mem_clr;
    assign ReadData = dmem[Address[6:0]];
    always @(posedge CLK) begin
        if (mem_clr) begin
            for (int i = 0; i < 128; i++) dmem[i] <= '0;
        end else if (RSTn && MemWrite) begin
            dmem[Address[6:0]] <= WriteData;
        end
    end

    // Reference model: flat little-endian byte array
    logic [7:0] mb [512];

    function automatic logic m_err(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd3) return 1'b1;
        if (sz == 2'd1 && a[0]) return 1'b1;
        if (sz == 2'd2 && a[1:0] != 2'b00) return 1'b1;
        return a >= 32'd512;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
        int n = 1 << sz;
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(mb[int'(a) + i]) << (8 * i));
        if (n < 4 && sg && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic m_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int n = 1 << sz;
        for (int i = 0; i < n; i++) mb[int'(a) + i] = 8'(wd >> (8 * i));
    endtask

    function automatic logic [31:0] m_word(input logic [31:0] a);
        logic [31:0] b = a & ~32'd3;
        return m_load(2'd2, 1'b0, b);
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Issue one request, scramble the inputs after accept, and collect what happened.
    task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output logic er, output int lat,
                           output int nr, output int nw, output logic [31:0] rd_a,
                           output logic [31:0] wr_a, output logic [31:0] wr_d);
        logic got = 1'b0;
        int   ovl = 0;
        @(negedge CLK);
        req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        for (int k = 0; k < 20 && !req_ready; k++) @(negedge CLK);
        chk1("accept_ready", req_ready, 1'b1);
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        req_addr = $urandom; req_wdata = $urandom;
        req_size = 2'($urandom); req_write = 1'($urandom); req_signed = 1'($urandom);
        rd = '0; er = 1'b0; lat = 0; nr = 0; nw = 0; rd_a = '1; wr_a = '1; wr_d = '0;
        for (int c = 1; c <= 10 && !got; c++) begin
            @(negedge CLK);
            if (MemRead && MemWrite) ovl++;
            if (MemRead) begin nr++; rd_a = Address; end
            if (MemWrite) begin nw++; wr_a = Address; wr_d = WriteData; end
            if (resp_valid) begin got = 1'b1; lat = c; rd = resp_rdata; er = resp_err; end
        end
        chk1("resp_seen", got, 1'b1);
        chk32("strobe_overlap", 32'(ovl), 32'd0);
        @(negedge CLK);
        chk1("resp_one_cycle", resp_valid, 1'b0);
        chk1("ready_after_resp", req_ready, 1'b1);
        chk1("no_strobe_after", MemRead | MemWrite, 1'b0);
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_nr;
        int          exp_nw;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic [31:0] rd, rd_a, wr_a, wr_d, exp_rd, exp_wd;
        logic        er, e;
        int          lat, nr, nw, busy;
        logic        w, sg;
        logic [1:0]  sz;
        logic [31:0] a, wd;

        vecs[0]  = '{1'b1, SZ_WORD, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 2, 0, 1, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, SZ_BYTE, 1'b1, 32'h13,  32'h0,        32'hFFFFFFDE, 1'b0, 2, 1, 0, 32'h0};
        vecs[2]  = '{1'b0, SZ_BYTE, 1'b0, 32'h13,  32'h0,        32'h000000DE, 1'b0, 2, 1, 0, 32'h0};
        vecs[3]  = '{1'b0, SZ_HALF, 1'b1, 32'h10,  32'h0,        32'hFFFFBEEF, 1'b0, 2, 1, 0, 32'h0};
        vecs[4]  = '{1'b0, SZ_HALF, 1'b0, 32'h12,  32'h0,        32'h0000DEAD, 1'b0, 2, 1, 0, 32'h0};
        vecs[5]  = '{1'b0, SZ_WORD, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 2, 1, 0, 32'h0};
        vecs[6]  = '{1'b1, SZ_BYTE, 1'b0, 32'h11,  32'h12345655, 32'h0,        1'b0, 3, 1, 1, 32'hDEAD55EF};
        vecs[7]  = '{1'b0, SZ_WORD, 1'b0, 32'h10,  32'h0,        32'hDEAD55EF, 1'b0, 2, 1, 0, 32'h0};
        vecs[8]  = '{1'b0, SZ_HALF, 1'b1, 32'h11,  32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0};
        vecs[9]  = '{1'b1, SZ_WORD, 1'b0, 32'h0E,  32'h11111111, 32'h0,        1'b1, 1, 0, 0, 32'h0};
        vecs[10] = '{1'b0, SZ_WORD, 1'b0, 32'h200, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0};
        vecs[11] = '{1'b0, SZ_RSVD, 1'b0, 32'h0,   32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0};

        for (int i = 0; i < 512; i++) mb[i] = 8'h00;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0;
        mem_clr = 1'b1;
        RSTn = 1'b1;
        #1 RSTn = 1'b0;
        #2;
        chk1("rst_ready", req_ready, 1'b1);
        chk1("rst_resp_valid", resp_valid, 1'b0);
        chk1("rst_resp_err", resp_err, 1'b0);
        chk32("rst_resp_rdata", resp_rdata, 32'h0);
        chk1("rst_memread", MemRead, 1'b0);
        chk1("rst_memwrite", MemWrite, 1'b0);
        chk32("rst_address", Address, 32'h0);
        chk32("rst_writedata", WriteData, 32'h0);
        repeat (3) @(negedge CLK);
        mem_clr = 1'b0;
        RSTn = 1'b1;

        // Directed vectors
        for (int i = 0; i < 12; i++) begin
            run_req(vecs[i].w, vecs[i].sz, vecs[i].sg, vecs[i].addr, vecs[i].wdata,
                    rd, er, lat, nr, nw, rd_a, wr_a, wr_d);
            chk32($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk1($sformatf("vec%0d_err", i), er, vecs[i].exp_err);
            chk32($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk32($sformatf("vec%0d_memread_cycles", i), 32'(nr), 32'(vecs[i].exp_nr));
            chk32($sformatf("vec%0d_memwrite_cycles", i), 32'(nw), 32'(vecs[i].exp_nw));
            if (vecs[i].exp_nr > 0) chk32($sformatf("vec%0d_rd_addr", i), rd_a, vecs[i].addr >> 2);
            if (vecs[i].exp_nw > 0) begin
                chk32($sformatf("vec%0d_wr_addr", i), wr_a, vecs[i].addr >> 2);
                chk32($sformatf("vec%0d_wr_data", i), wr_d, vecs[i].exp_wd);
            end
            if (!vecs[i].exp_err && vecs[i].w) m_store(vecs[i].sz, vecs[i].addr, vecs[i].wdata);
        end

        // Reset during the read phase of sh 0x12 abandons the store
        @(negedge CLK);
        req_write = 1'b1; req_size = SZ_HALF; req_signed = 1'b0;
        req_addr = 32'h12; req_wdata = 32'h0000AAAA; req_valid = 1'b1;
        @(posedge CLK);
        #1 req_valid = 1'b0;
        chk1("rst_mid_memread_before", MemRead, 1'b1);
        #2 RSTn = 1'b0;
        #1;
        chk1("rst_mid_memread", MemRead, 1'b0);
        chk1("rst_mid_memwrite", MemWrite, 1'b0);
        chk32("rst_mid_address", Address, 32'h0);
        chk32("rst_mid_writedata", WriteData, 32'h0);
        chk1("rst_mid_resp_valid", resp_valid, 1'b0);
        chk32("rst_mid_resp_rdata", resp_rdata, 32'h0);
        @(negedge CLK);
        RSTn = 1'b1;
        @(posedge CLK);
        #1;
        chk1("rst_mid_ready_after", req_ready, 1'b1);
        chk1("rst_mid_no_write", MemWrite, 1'b0);
        run_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, rd, er, lat, nr, nw, rd_a, wr_a, wr_d);
        chk32("rst_mid_lw_rdata", rd, 32'hDEAD55EF);
        chk1("rst_mid_lw_err", er, 1'b0);

        // req_valid held through a busy sub-word store while req_addr wanders
        @(negedge CLK);
        req_write = 1'b1; req_size = SZ_BYTE; req_signed = 1'b0;
        req_addr = 32'h20; req_wdata = 32'h000000A5; req_valid = 1'b1;
        @(posedge CLK);
        #1;
        req_write = 1'b0; req_size = SZ_WORD;
        busy = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            if (req_ready) break;
            busy++;
            if (MemRead || MemWrite) chk32("held_strobe_addr", Address, 32'h8);
            req_addr = 32'($urandom_range(0, 127)) << 2;
        end
        chk32("held_busy_cycles", 32'(busy), 32'd3);
        m_store(SZ_BYTE, 32'h20, 32'h000000A5);
        req_addr = 32'h10;
        @(posedge CLK);
        #1 req_valid = 1'b0;
        rd = '1; er = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            if (resp_valid) begin rd = resp_rdata; er = resp_err; break; end
        end
        chk32("held_final_rdata", rd, 32'hDEAD55EF);
        chk1("held_final_err", er, 1'b0);
        run_req(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, rd, er, lat, nr, nw, rd_a, wr_a, wr_d);
        chk32("held_store_committed", rd, m_word(32'h20));

        // Random requests against the byte model
        for (int it = 0; it < 300; it++) begin
            w  = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            wd = $urandom;
            if ($urandom_range(0, 19) == 0) a = $urandom;
            else a = 32'($urandom_range(0, 575));
            if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
            e = m_err(sz, a);
            exp_rd = '0; exp_wd = '0;
            if (!e && !w) exp_rd = m_load(sz, sg, a);
            if (!e && w) begin
                m_store(sz, a, wd);
                exp_wd = m_word(a);
            end
            run_req(w, sz, sg, a, wd, rd, er, lat, nr, nw, rd_a, wr_a, wr_d);
            chk1("rand_err", er, e);
            chk32("rand_rdata", rd, exp_rd);
            if (e) begin
                chk32("rand_err_latency", 32'(lat), 32'd1);
                chk32("rand_err_strobes", 32'(nr + nw), 32'd0);
            end else if (!w) begin
                chk32("rand_ld_latency", 32'(lat), 32'd2);
                chk32("rand_ld_reads", 32'(nr), 32'd1);
                chk32("rand_ld_writes", 32'(nw), 32'd0);
                chk32("rand_ld_addr", rd_a, a >> 2);
            end else begin
                chk32("rand_st_latency", 32'(lat), (sz == SZ_WORD) ? 32'd2 : 32'd3);
                chk32("rand_st_reads", 32'(nr), (sz == SZ_WORD) ? 32'd0 : 32'd1);
                chk32("rand_st_writes", 32'(nw), 32'd1);
                chk32("rand_st_addr", wr_a, a >> 2);
                chk32("rand_st_wdata", wr_d, exp_wd);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
